// File: rtl/spi_cs_arbiter.sv
// Purpose: round-robin share of one spi_master between two requesters, with CS setup/hold/gap timing.
// Latency: req->gnt/select low 1 cycle, m_start CS_SETUP later, done CS_HOLD after m_done (or after timeout).
// Backpressure: req is held until gnt; req is sampled only in IDLE; the master is paced by m_start/m_done.
module spi_cs_arbiter #(
    parameter int DATA_W   = 8,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int GAP      = 4,
    parameter int TIMEOUT  = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              err,
    output logic              m_start,
    output logic [DATA_W-1:0] m_txdata,
    input  logic              m_done,
    input  logic [DATA_W-1:0] m_rxdata,
    output logic              s0,
    output logic              s1
);

    // One counter serves every timed state, so size it for the longest one.
    localparam int MAX_A = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int MAX_B = (GAP > TIMEOUT) ? GAP : TIMEOUT;
    localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAX_C + 1);

    // The m_done cycle itself counts as the first hold cycle, so HOLD lasts CS_HOLD-1 cycles.
    localparam bit            HOLD_SKIP  = (CS_HOLD == 1);
    localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'((CS_HOLD > 1) ? (CS_HOLD - 2) : 0);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP - 1);
    localparam logic [CW-1:0] TO_LAST    = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_START,
        ST_XFER,
        ST_HOLD,
        ST_GAP
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     w_cnt_nxt;
    logic              r_rr;          // 0: slave 0 wins the next tie
    logic              w_rr_nxt;
    logic              w_grant;
    logic              w_win;         // 0: slave 0, 1: slave 1
    logic              w_xfer_end;
    logic              w_timeout;
    logic              w_finish;

    logic              r_sel;
    logic              r_err_flag;
    logic              r_gnt0;
    logic              r_gnt1;
    logic              r_done0;
    logic              r_done1;
    logic              r_err;
    logic              r_m_start;
    logic              r_s0;
    logic              r_s1;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
    logic [DATA_W-1:0] r_m_txdata;

    // State register, per-state cycle counter and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_rr    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rr    <= w_rr_nxt;
        end
    end

    // Next-state logic: arbitration in IDLE, then the fixed select/transfer sequence.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rr_nxt    = r_rr;
        w_grant     = 1'b0;
        w_win       = 1'b0;
        w_xfer_end  = 1'b0;
        w_timeout   = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req0 || req1) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ST_SETUP;
                    w_cnt_nxt   = '0;
                    if (req0 && req1) begin
                        w_win    = r_rr;
                        w_rr_nxt = ~r_rr;
                    end else begin
                        w_win = req1;
                    end
                end
            end
            ST_SETUP: begin
                if (r_cnt == SETUP_LAST) begin
                    w_state_nxt = ST_START;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            ST_START: begin
                // m_done in the m_start cycle is not looked at here.
                w_state_nxt = ST_XFER;
                w_cnt_nxt   = '0;
            end
            ST_XFER: begin
                if (m_done) begin
                    w_xfer_end = 1'b1;
                end else if (r_cnt == TO_LAST) begin
                    w_xfer_end = 1'b1;
                    w_timeout  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
                if (w_xfer_end) begin
                    w_cnt_nxt = '0;
                    if (HOLD_SKIP) begin
                        w_finish    = 1'b1;
                        w_state_nxt = ST_GAP;
                    end else begin
                        w_state_nxt = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (r_cnt == HOLD_LAST) begin
                    w_finish    = 1'b1;
                    w_state_nxt = ST_GAP;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            ST_GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Registered outputs: pulses, selects, captured tx byte and per-requester rx bytes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel      <= 1'b0;
            r_err_flag <= 1'b0;
            r_gnt0     <= 1'b0;
            r_gnt1     <= 1'b0;
            r_done0    <= 1'b0;
            r_done1    <= 1'b0;
            r_err      <= 1'b0;
            r_m_start  <= 1'b0;
            r_s0       <= 1'b1;
            r_s1       <= 1'b1;
            r_rdata0   <= '0;
            r_rdata1   <= '0;
            r_m_txdata <= '0;
        end else begin
            r_gnt0    <= w_grant & ~w_win;
            r_gnt1    <= w_grant & w_win;
            r_m_start <= (w_state_nxt == ST_START);
            r_done0   <= w_finish & ~r_sel;
            r_done1   <= w_finish & r_sel;
            r_err     <= w_finish & (r_err_flag | w_timeout);
            if (w_grant) begin
                r_sel      <= w_win;
                r_err_flag <= 1'b0;
                r_m_txdata <= w_win ? wdata1 : wdata0;
                r_s0       <= w_win;
                r_s1       <= ~w_win;
            end
            if (w_xfer_end) begin
                r_err_flag <= w_timeout;
                if (r_sel) begin
                    r_rdata1 <= w_timeout ? '0 : m_rxdata;
                end else begin
                    r_rdata0 <= w_timeout ? '0 : m_rxdata;
                end
            end
            if (w_finish) begin
                r_s0 <= 1'b1;
                r_s1 <= 1'b1;
            end
        end
    end

    assign gnt0     = r_gnt0;
    assign gnt1     = r_gnt1;
    assign done0    = r_done0;
    assign done1    = r_done1;
    assign err      = r_err;
    assign m_start  = r_m_start;
    assign m_txdata = r_m_txdata;
    assign rdata0   = r_rdata0;
    assign rdata1   = r_rdata1;
    assign s0       = r_s0;
    assign s1       = r_s1;

endmodule

// File: tb/tb_spi_cs_arbiter.sv
// Bench for spi_cs_arbiter: directed scenarios followed by a randomized request mix.
// Expected grant order, timing and rx bytes come from a transaction-level model.
// The master side is played inline by the stimulus sequence.
module tb_spi_cs_arbiter;

    localparam int DW       = 8;
    localparam int CS_SETUP = 2;
    localparam int CS_HOLD  = 2;
    localparam int GAP      = 4;
    localparam int TIMEOUT  = 1023;

    logic          clk;
    logic          rst;
    logic          req0, req1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, done0, done1;
    logic [DW-1:0] rdata0, rdata1;
    logic          err, m_start;
    logic [DW-1:0] m_txdata;
    logic          m_done;
    logic [DW-1:0] m_rxdata;
    logic          s0, s1;

    spi_cs_arbiter #(
        .DATA_W(DW), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .GAP(GAP), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata0(rdata0), .rdata1(rdata1), .err(err),
        .m_start(m_start), .m_txdata(m_txdata), .m_done(m_done), .m_rxdata(m_rxdata),
        .s0(s0), .s1(s1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    bit mon_en = 1'b0;

    // Model state: round-robin pointer and last rx byte seen by each requester.
    int         m_rr;
    logic [7:0] m_rd [2];

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        tests++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, want, cyc);
        end
    endtask

    // Winner rule: a lone requester wins; a tie goes to the pointer side, which then moves over.
    task automatic pick(input logic r0, input logic r1, output int w);
        if (r0 && r1) begin
            w    = m_rr;
            m_rr = 1 - m_rr;
        end else begin
            w = r1 ? 1 : 0;
        end
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        req0   = 1'b0;
        req1   = 1'b0;
        m_done = 1'b0;
        repeat (2) tick();
        rst     = 1'b0;
        m_rr    = 0;
        m_rd[0] = 8'h00;
        m_rd[1] = 8'h00;
    endtask

    // One complete transfer; lat=0 means the master never answers.
    task automatic xfer(input int side, input logic [7:0] tx, input int lat,
                        input logic [7:0] rx, input bit spur, input bit drop,
                        input int exp_tg, output int td);
        int         tg, tm, ed;
        bit         seen;
        logic [7:0] want_rd;
        td   = cyc;
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            tick();
            if (gnt0 || gnt1) seen = 1'b1;
        end
        chk("gnt_seen", seen, 1);
        if (!seen) return;
        tg = cyc;
        chk("gnt_cycle", tg, exp_tg);
        chk("gnt_side", {gnt1, gnt0}, (side == 1) ? 2 : 1);
        chk("sel_low", {s1, s0}, (side == 1) ? 1 : 2);
        if (drop) begin
            if (side == 1) req1 = 1'b0;
            else           req0 = 1'b0;
        end
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            if (m_start) seen = 1'b1;
        end
        chk("start_seen", seen, 1);
        if (!seen) return;
        tm = cyc;
        chk("start_lat", tm - tg, CS_SETUP);
        chk("txdata", m_txdata, tx);
        if (spur) begin
            m_done   = 1'b1;
            m_rxdata = 8'hEE;
        end
        if (lat > 0) begin
            for (int k = 0; k < lat; k++) begin
                tick();
                m_done = 1'b0;
                if (k == 0) chk("start_pulse", m_start, 0);
                chk("sel_xfer", (side == 1) ? s1 : s0, 0);
            end
            chk("tx_stable", m_txdata, tx);
            m_done   = 1'b1;
            m_rxdata = rx;
            tick();
            m_done   = 1'b0;
            m_rxdata = 8'($urandom);
            ed      = tm + lat + CS_HOLD;
            want_rd = rx;
        end else begin
            tick();
            m_done  = 1'b0;
            ed      = tm + TIMEOUT + CS_HOLD;
            want_rd = 8'h00;
        end
        seen = 1'b0;
        for (int k = 0; k < TIMEOUT + 50 && !seen; k++) begin
            if (done0 || done1 || err) seen = 1'b1;
            else tick();
        end
        chk("done_seen", seen, 1);
        if (!seen) return;
        td = cyc;
        chk("done_cycle", td, ed);
        chk("done_side", {done1, done0}, (side == 1) ? 2 : 1);
        chk("err", err, (lat == 0) ? 1 : 0);
        chk("sel_high_at_done", {s1, s0}, 3);
        m_rd[side] = want_rd;
        chk("rdata0", rdata0, m_rd[0]);
        chk("rdata1", rdata1, m_rd[1]);
        tick();
        chk("done_pulse", {done1, done0, err}, 0);
    endtask

    // The two selects must never be low together.
    always @(negedge clk) begin
        if (mon_en) chk("sel_exclusive", s0 | s1, 1);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int         td, c, w, lat, exp_tg;
        bit         seen, p0, p1;
        logic [1:0] sel;
        logic [7:0] wd0, wd1, rx;

        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; wdata0 = '0; wdata1 = '0;
        m_done = 1'b0; m_rxdata = '0;
        m_rr = 0; m_rd[0] = 8'h00; m_rd[1] = 8'h00;
        repeat (3) tick();

        // Reset state
        chk("rst_sel", {s1, s0}, 3);
        chk("rst_pulses", {gnt0, gnt1, done0, done1, err, m_start}, 0);
        chk("rst_rdata", {rdata1, rdata0}, 0);
        chk("rst_txdata", m_txdata, 0);
        rst    = 1'b0;
        mon_en = 1'b1;

        // 1: single request, master answers 16 cycles after m_start
        wdata0 = 8'hA5; req0 = 1'b1; c = cyc;
        pick(1'b1, 1'b0, w);
        xfer(w, 8'hA5, 16, 8'h3C, 1'b0, 1'b1, c + 1, td);

        // 2: simultaneous requests out of reset, each dropped after its grant
        do_reset();
        wd0 = 8'h12; wd1 = 8'h34; wdata0 = wd0; wdata1 = wd1;
        req0 = 1'b1; req1 = 1'b1; c = cyc;
        pick(1'b1, 1'b1, w);
        xfer(w, (w == 1) ? wd1 : wd0, 5, 8'h81, 1'b0, 1'b1, c + 1, td);
        pick(req0, req1, w);
        xfer(w, (w == 1) ? wd1 : wd0, 3, 8'h18, 1'b1, 1'b1, td + GAP + 1, td);

        // 3: both requests held high across four transfers
        do_reset();
        wd0 = 8'h5A; wd1 = 8'hC7; wdata0 = wd0; wdata1 = wd1;
        req0 = 1'b1; req1 = 1'b1; c = cyc;
        for (int i = 0; i < 4; i++) begin
            pick(1'b1, 1'b1, w);
            exp_tg = (i == 0) ? c + 1 : td + GAP + 1;
            lat    = $urandom_range(1, 20);
            rx     = 8'($urandom);
            xfer(w, (w == 1) ? wd1 : wd0, lat, rx, 1'b0, 1'b0, exp_tg, td);
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (GAP + 2) tick();

        // 4: normal transfer on slave 1, then a timed-out one, then a normal one again
        do_reset();
        wdata1 = 8'h21; req1 = 1'b1; c = cyc;
        pick(1'b0, 1'b1, w);
        xfer(w, 8'h21, 10, 8'h77, 1'b0, 1'b1, c + 1, td);
        wdata1 = 8'h11; req1 = 1'b1;
        pick(1'b0, 1'b1, w);
        xfer(w, 8'h11, 0, 8'h00, 1'b0, 1'b1, td + GAP + 1, td);
        wdata1 = 8'h22; req1 = 1'b1;
        pick(1'b0, 1'b1, w);
        xfer(w, 8'h22, 6, 8'h5A, 1'b0, 1'b1, td + GAP + 1, td);
        repeat (GAP + 2) tick();

        // 5: reset while slave 1 is mid-transfer
        wdata1 = 8'h3E; req1 = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            if (gnt1) seen = 1'b1;
        end
        chk("r5_gnt1_seen", seen, 1);
        req1 = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            if (m_start) seen = 1'b1;
        end
        chk("r5_start_seen", seen, 1);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        chk("r5_sel_high", {s1, s0}, 3);
        chk("r5_pulses", {gnt0, gnt1, done0, done1, err, m_start}, 0);
        chk("r5_rdata_clear", {rdata1, rdata0}, 0);
        rst = 1'b0; m_rr = 0; m_rd[0] = 8'h00; m_rd[1] = 8'h00;
        m_done = 1'b1; m_rxdata = 8'h99;
        tick();
        m_done = 1'b0;
        for (int k = 0; k < 30; k++) begin
            chk("r5_no_done", {done0, done1, err, gnt0, gnt1, m_start}, 0);
            tick();
        end
        wdata0 = 8'h5C; req0 = 1'b1; c = cyc;
        pick(1'b1, 1'b0, w);
        xfer(w, 8'h5C, 7, 8'hC3, 1'b0, 1'b1, c + 1, td);

        // 6: a one-cycle req1 during GAP (plus a stray m_done) must be ignored
        wdata1 = 8'h66; req1 = 1'b1;
        tick();
        req1 = 1'b0; m_done = 1'b1; m_rxdata = 8'h42;
        tick();
        m_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            chk("g6_ignored", {gnt0, gnt1, m_start, done0, done1, err}, 0);
            chk("g6_sel_high", {s1, s0}, 3);
            tick();
        end
        chk("g6_rdata1", rdata1, m_rd[1]);
        chk("g6_rdata0", rdata0, m_rd[0]);

        // Randomized request mix against the model
        do_reset();
        td = -1000; p0 = 1'b0; p1 = 1'b0;
        for (int it = 0; it < 16; it++) begin
            if (!(p0 || p1)) repeat ($urandom_range(0, 8)) tick();
            sel = (p0 || p1) ? 2'($urandom_range(0, 3)) : 2'($urandom_range(1, 3));
            if (sel[0] && !p0) begin
                p0 = 1'b1; wd0 = 8'($urandom); wdata0 = wd0; req0 = 1'b1;
            end
            if (sel[1] && !p1) begin
                p1 = 1'b1; wd1 = 8'($urandom); wdata1 = wd1; req1 = 1'b1;
            end
            c = cyc;
            pick(p0, p1, w);
            exp_tg = (td + GAP + 1 > c + 1) ? td + GAP + 1 : c + 1;
            lat    = $urandom_range(1, 40);
            rx     = 8'($urandom);
            xfer(w, (w == 1) ? wd1 : wd0, lat, rx, ($urandom_range(0, 3) == 0), 1'b1, exp_tg, td);
            if (w == 1) p1 = 1'b0;
            else        p0 = 1'b0;
        end
        repeat (GAP + 4) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
